opponent_state_rx: RTL
======================

// Module: opponent_state_rx
// PURPOSE
//   UART receiver and packet parser for the two-board race link. Deserialises the opponent board's car-state
//   packets and drives the opponent-car inputs of the physics engine: front/rear collision centres, angle, lap
//   flag and finish. Updates are atomic and checksum-gated. A stale link parks the opponent off-map.
// PARAMETERS
//   CLK_FREQ      100_000_000  system clock in Hz
//   BAUD          115_200      line rate; BIT_TICKS = CLK_FREQ/BAUD (868 at defaults)
//   SYNC_BYTE     8'hA5        packet start marker
//   RST_X         10'd1023     parked opponent x (off-map, so it never collides)
//   RST_Y         10'd1023     parked opponent y
//   LINK_TIMEOUT  CLK_FREQ/10  clocks without a good packet before link_up drops (100 ms)
// PORTS
//   clk            in   1   system clock
//   rst            in   1   asynchronous, active-high reset
//   rxd            in   1   UART line, idle high, asynchronous to clk
//   other_f_x/f_y  out  10  opponent front collision centre
//   other_r_x/r_y  out  10  opponent rear collision centre
//   other_angle    out  4   opponent angle_idx
//   other_flag     out  2   opponent checkpoint flag
//   other_finish   out  1   opponent finished
//   pkt_valid      out  1   one-cycle pulse when the outputs above update
//   link_up        out  1   good packet received within LINK_TIMEOUT
//   err_cnt        out  8   saturating count of framing + checksum errors
// BEHAVIOUR
//   Reset (async): coordinates = RST_X/RST_Y; angle, flag, finish, pkt_valid, link_up, err_cnt = 0; parser in HUNT.
//   Line format: 8N1, LSB first. rxd passes through a 2-flop synchroniser before any use.
//   Byte RX:
//     - Start = falling edge while idle. At BIT_TICKS/2, rxd must still be low; otherwise false start, return to idle.
//     - Sample 8 data bits at BIT_TICKS spacing, then the stop bit.
//     - Stop = 1: byte_valid pulses 1 cycle with the byte.
//     - Stop = 0: frame_err pulses 1 cycle, no byte is delivered, then wait for rxd high before re-arming.
//   Packet: SYNC_BYTE, P0..P5, CHK, where CHK = P0^P1^...^P5.
//     - W[47:0] = {P0..P5}, P0 sent first. W = {1'b0, finish, flag[1:0], angle[3:0], f_x, f_y, r_x, r_y}.
//   Parser FSM (states HUNT, PAYLOAD, CHECK):
//     - HUNT: a byte == SYNC_BYTE goes to PAYLOAD with idx=0 and the XOR accumulator cleared. Other bytes are dropped.
//     - PAYLOAD: shift each byte into the shadow register and XOR it into the accumulator. After idx=5, go to CHECK.
//     - CHECK, CHK == accumulator: shadow -> outputs 1 cycle after CHK's byte_valid. pkt_valid pulses that
//       same cycle, the link timer clears, link_up = 1. Return to HUNT.
//     - CHECK, CHK mismatch: err_cnt++ (saturates at 255), outputs unchanged, return to HUNT.
//     - SYNC_BYTE inside the payload is ordinary data; there is no escaping and parsing is positional.
//     - frame_err in any state: err_cnt++ and return to HUNT.
//     - Inter-byte gap > 4*10*BIT_TICKS while in PAYLOAD/CHECK: abort to HUNT, no error counted.
//   Link timer:
//     - Increments every cycle and saturates.
//     - Reaching LINK_TIMEOUT: link_up = 0 and coordinates revert to RST_X/RST_Y. Angle, flag and finish are held.
//     - A valid packet in the same cycle as the timeout wins.
//   err_cnt and a simultaneous pkt_valid are independent; they never occur together by construction.
//   The outputs are registered and never show a partial packet.
// STRUCTURE
//   Shared package/header: SYNC_BYTE, PKT_PAYLOAD_BYTES = 6, W bit-field offsets, RST_X/RST_Y. The
//   opponent_state_tx serialiser uses the same constants.
//   Sub-module uart_rx_byte(clk, rst, rxd, byte_out[7:0], byte_valid, frame_err) holds the synchroniser, the
//   bit counter and the sampler. The parser FSM, shadow register and link timer stay in this module.
// TESTING (bench BAUD = CLK_FREQ/16 for speed; TB UART model drives rxd)
//   1. Good packet, f=(200,100), r=(196,100), angle=4, flag=2, finish=0
//      -> single pkt_valid; outputs match; link_up = 1; err_cnt = 0.
//   2. Same packet with CHK^8'h01
//      -> no pkt_valid; outputs hold previous values; err_cnt = 1. A following good packet is accepted.
//   3. Stop bit forced 0 on P2
//      -> err_cnt++, parser back to HUNT. Next packet with P0 = A5 inside the payload parses correctly.
//   4. 2-cycle low glitch on idle rxd -> no byte_valid, no state change.
//   5. After a good packet, idle for LINK_TIMEOUT
//      -> link_up = 0, coordinates = 1023, angle/flag held. A new packet restores them.
//   6. rst asserted mid-payload (after P3) -> outputs at reset values immediately.
//      After release, the next full packet is accepted.

Source files
------------

// File: rtl/opponent_state_rx_pkg.sv
// Shared constants for the two-board race link: packet framing, payload field offsets and parked position.
// The opponent_state_tx serialiser packs its payload with the same offsets.
package opponent_state_rx_pkg;

  localparam logic [7:0] PKT_SYNC_BYTE     = 8'hA5;
  localparam int         PKT_PAYLOAD_BYTES = 6;
  localparam logic [9:0] PKT_RST_X         = 10'd1023;
  localparam logic [9:0] PKT_RST_Y         = 10'd1023;

  // Payload word W[47:0] = {1'b0, finish, flag[1:0], angle[3:0], f_x, f_y, r_x, r_y}
  localparam int W_RY_LSB     = 0;
  localparam int W_RX_LSB     = 10;
  localparam int W_FY_LSB     = 20;
  localparam int W_FX_LSB     = 30;
  localparam int W_ANGLE_LSB  = 40;
  localparam int W_FLAG_LSB   = 44;
  localparam int W_FINISH_BIT = 46;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CHECK
  } parser_state_e;

endpackage

// File: rtl/opponent_state_rx_uart_rx_byte.sv
// 8N1 UART byte receiver: synchroniser, mid-bit sampler, one-cycle byte_valid / frame_err pulses.
module uart_rx_byte
  import opponent_state_rx_pkg::*;
#(
  parameter int unsigned BIT_TICKS = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned HALF_TICKS = BIT_TICKS / 2;
  localparam int          CNT_W      = $clog2(BIT_TICKS);

  logic            rxMeta_q, rxSync_q;
  rx_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      bitIdx_q, bitIdx_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      rxMeta_q <= rxd;
      rxSync_q <= rxMeta_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
    end
  end

  // The start bit is re-checked half a bit in, so every later sample lands mid-bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rxSync_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == CNT_W'(HALF_TICKS - 1)) begin
          cnt_d    = '0;
          bitIdx_d = '0;
          state_d  = rxSync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_W'(BIT_TICKS - 1)) begin
          cnt_d    = '0;
          shift_d  = {rxSync_q, shift_q[7:1]};
          bitIdx_d = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) begin
            state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_W'(BIT_TICKS - 1)) begin
          cnt_d = '0;
          if (rxSync_q) begin
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (rxSync_q) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_out   = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/opponent_state_rx.sv
// Opponent car-state receiver: parses SYNC/P0..P5/CHK packets, commits them atomically when the XOR
// checksum matches, and parks the opponent off-map when the link goes stale.
module opponent_state_rx
  import opponent_state_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter logic [7:0]  SYNC_BYTE    = PKT_SYNC_BYTE,
  parameter logic [9:0]  RST_X        = PKT_RST_X,
  parameter logic [9:0]  RST_Y        = PKT_RST_Y,
  parameter int unsigned LINK_TIMEOUT = CLK_FREQ / 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [9:0] other_f_x,
  output logic [9:0] other_f_y,
  output logic [9:0] other_r_x,
  output logic [9:0] other_r_y,
  output logic [3:0] other_angle,
  output logic [1:0] other_flag,
  output logic       other_finish,
  output logic       pkt_valid,
  output logic       link_up,
  output logic [7:0] err_cnt
);

  localparam int unsigned BIT_TICKS = CLK_FREQ / BAUD;
  localparam int unsigned GAP_TICKS = 4 * 10 * BIT_TICKS;
  localparam int          GAP_W     = $clog2(GAP_TICKS + 1);
  localparam int          LT_W      = $clog2(LINK_TIMEOUT + 1);

  logic [7:0] rxByte;
  logic       byteValid, frameErr;

  uart_rx_byte #(.BIT_TICKS(BIT_TICKS)) uRx (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .byte_out   (rxByte),
    .byte_valid (byteValid),
    .frame_err  (frameErr)
  );

  parser_state_e    state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       acc_q, acc_d;
  logic [46:0]      shadow_q, shadow_d;
  logic [GAP_W-1:0] gapCnt_q, gapCnt_d;
  logic [LT_W-1:0]  linkCnt_q;
  logic             accept, chkErr;

  logic [9:0] frontX_q, frontY_q, rearX_q, rearY_q;
  logic [3:0] angle_q;
  logic [1:0] flag_q;
  logic       finish_q, pktValid_q, link_q;
  logic [7:0] errCnt_q;

  // Parsing is positional: a sync byte inside the payload is just data.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    shadow_d = shadow_q;
    gapCnt_d = gapCnt_q;
    accept   = 1'b0;
    chkErr   = 1'b0;
    case (state_q)
      HUNT: begin
        if (byteValid && rxByte == SYNC_BYTE) begin
          state_d = PAYLOAD;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      PAYLOAD: begin
        if (byteValid) begin
          shadow_d = {shadow_q[38:0], rxByte};
          acc_d    = acc_q ^ rxByte;
          idx_d    = idx_q + 3'd1;
          if (idx_q == 3'(PKT_PAYLOAD_BYTES - 1)) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (byteValid) begin
          if (rxByte == acc_q) begin
            accept = 1'b1;
          end else begin
            chkErr = 1'b1;
          end
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase

    if (state_q == HUNT || byteValid) begin
      gapCnt_d = '0;
    end else if (gapCnt_q == GAP_W'(GAP_TICKS)) begin
      gapCnt_d = '0;
      state_d  = HUNT;
    end else begin
      gapCnt_d = gapCnt_q + 1'b1;
    end

    if (frameErr) begin
      state_d = HUNT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      idx_q    <= '0;
      acc_q    <= '0;
      shadow_q <= '0;
      gapCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      shadow_q <= shadow_d;
      gapCnt_q <= gapCnt_d;
    end
  end

  // A packet accepted on the timeout cycle wins, since the commit branch is checked first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frontX_q   <= RST_X;
      frontY_q   <= RST_Y;
      rearX_q    <= RST_X;
      rearY_q    <= RST_Y;
      angle_q    <= '0;
      flag_q     <= '0;
      finish_q   <= 1'b0;
      pktValid_q <= 1'b0;
      link_q     <= 1'b0;
      linkCnt_q  <= '0;
      errCnt_q   <= '0;
    end else begin
      pktValid_q <= accept;
      if (accept) begin
        frontX_q  <= shadow_q[W_FX_LSB +: 10];
        frontY_q  <= shadow_q[W_FY_LSB +: 10];
        rearX_q   <= shadow_q[W_RX_LSB +: 10];
        rearY_q   <= shadow_q[W_RY_LSB +: 10];
        angle_q   <= shadow_q[W_ANGLE_LSB +: 4];
        flag_q    <= shadow_q[W_FLAG_LSB +: 2];
        finish_q  <= shadow_q[W_FINISH_BIT];
        link_q    <= 1'b1;
        linkCnt_q <= '0;
      end else begin
        if (linkCnt_q != LT_W'(LINK_TIMEOUT)) begin
          linkCnt_q <= linkCnt_q + 1'b1;
        end
        if (linkCnt_q == LT_W'(LINK_TIMEOUT - 1)) begin
          link_q   <= 1'b0;
          frontX_q <= RST_X;
          frontY_q <= RST_Y;
          rearX_q  <= RST_X;
          rearY_q  <= RST_Y;
        end
      end
      if ((frameErr || chkErr) && errCnt_q != 8'hFF) begin
        errCnt_q <= errCnt_q + 8'd1;
      end
    end
  end

  assign other_f_x    = frontX_q;
  assign other_f_y    = frontY_q;
  assign other_r_x    = rearX_q;
  assign other_r_y    = rearY_q;
  assign other_angle  = angle_q;
  assign other_flag   = flag_q;
  assign other_finish = finish_q;
  assign pkt_valid    = pktValid_q;
  assign link_up      = link_q;
  assign err_cnt      = errCnt_q;

endmodule
